// File: rtl/seeg_axis_frame_packer_if.sv
// rtl/seeg_axis_frame_packer_if.sv - AXI-Stream link carrying packed SEEG frames
interface seeg_axis_frame_packer_if #(
    parameter int TDATA_W = 64
);
    logic [TDATA_W-1:0]   M_AXIS_TDATA;
    logic [TDATA_W/8-1:0] M_AXIS_TKEEP;
    logic                 M_AXIS_TLAST;
    logic                 M_AXIS_TVALID;
    logic                 M_AXIS_TREADY;

    modport master (
        output M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TVALID,
        input  M_AXIS_TREADY
    );

    modport slave (
        input  M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TVALID,
        output M_AXIS_TREADY
    );
endinterface

// File: rtl/seeg_axis_frame_packer.sv
// rtl/seeg_axis_frame_packer.sv - packs masked channel-serial samples into one stream packet per frame
module seeg_axis_frame_packer #(
    parameter int NUM_CH     = 32,
    parameter int SAMPLE_W   = 16,
    parameter int TDATA_W    = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    M_AXIS_ACLK,
    input  logic                    M_AXIS_ARESETN,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic                    s_valid,
    input  logic                    s_sof,
    input  logic [SAMPLE_W-1:0]     s_data,
    seeg_axis_frame_packer_if.master m_axis,
    output logic [15:0]             frame_cnt,
    output logic [15:0]             drop_cnt,
    output logic [15:0]             err_cnt
);
    localparam int L   = TDATA_W / SAMPLE_W;
    localparam int KW  = TDATA_W / 8;
    localparam int SB  = SAMPLE_W / 8;
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LW  = $clog2(L) + 1;
    localparam int EW  = $clog2(NUM_CH + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int FW  = 1 + KW + TDATA_W;

    typedef enum logic [1:0] {IDLE, RUN, FILL, DROP} state_t;

    state_t              state_q, state_d;
    logic [CHW-1:0]      ch_q, ch_d, last_q, last_d, li;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [EW-1:0]       nw_q, nw_d, words_q, words_d, pc, nw_calc;
    logic [LW-1:0]       lastn_q, lastn_d, lanes_q, lanes_d, lastn_calc;
    logic [TDATA_W-1:0]  pack_q, pack_d, word_w;
    logic                flush_q, flush_d, fits, tl;
    logic [15:0]         frame_q, frame_d, drop_q, drop_d, err_q, err_d;
    int                  free_words;

    logic [FW-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         mem_cnt_q;
    logic                out_valid_q, wr_en, rd_en;
    logic [FW-1:0]       out_q, wr_entry;

    function automatic logic [KW-1:0] keep_of(input logic [LW-1:0] n);
        logic [KW-1:0] k;
        for (int b = 0; b < KW; b++) k[b] = (b < int'(n) * SB);
        return k;
    endfunction

    function automatic logic [TDATA_W-1:0] put_lane(input logic [TDATA_W-1:0] w,
                                                    input logic [LW-1:0] idx,
                                                    input logic [SAMPLE_W-1:0] s);
        logic [TDATA_W-1:0] r;
        r = w;
        for (int i = 0; i < L; i++)
            if (int'(idx) == i) r[i*SAMPLE_W +: SAMPLE_W] = s;
        return r;
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    always_comb begin
        pc = '0;
        li = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_mask[i]) begin
                pc = pc + EW'(1);
                li = CHW'(i);
            end
        end
        nw_calc    = EW'((int'(pc) + L - 1) / L);
        lastn_calc = LW'((int'(pc) % L == 0) ? L : int'(pc) % L);
        free_words = FIFO_DEPTH - int'(mem_cnt_q) - int'(out_valid_q);
        // A pending single-lane flush owns the next write slot, so a new header must wait
        fits       = !flush_q && (int'(nw_calc) + 1 <= free_words);
    end

    always_comb begin
        state_d = state_q;  ch_d = ch_q;     mask_d = mask_q;   last_d = last_q;
        nw_d = nw_q;        lastn_d = lastn_q; pack_d = pack_q; lanes_d = lanes_q;
        words_d = words_q;  flush_d = 1'b0;
        frame_d = frame_q;  drop_d = drop_q; err_d = err_q;
        wr_en = 1'b0;       wr_entry = '0;   word_w = '0;       tl = 1'b0;
        case (state_q)
            IDLE, DROP: begin
                if (s_valid && s_sof) begin
                    frame_d = frame_q + 16'd1;
                    if (fits) begin
                        wr_en    = 1'b1;
                        wr_entry = {pc == '0, {KW{1'b1}},
                                    {{(TDATA_W-48){1'b0}}, 16'(pc), frame_q, 16'hEE6A}};
                        mask_d   = ch_mask;
                        last_d   = li;
                        nw_d     = nw_calc;
                        lastn_d  = lastn_calc;
                        ch_d     = '0;
                        words_d  = '0;
                        pack_d   = ch_mask[0] ? put_lane('0, '0, s_data) : '0;
                        lanes_d  = ch_mask[0] ? LW'(1) : '0;
                        // Channel 0 alone completing the frame is written one edge after the header
                        flush_d  = ch_mask[0] && (li == '0);
                        state_d  = (NUM_CH == 1) ? IDLE : RUN;
                    end else begin
                        drop_d  = sat16(drop_q);
                        state_d = DROP;
                    end
                end
            end
            RUN: begin
                if (s_valid && s_sof) begin
                    frame_d = frame_q + 16'd1;
                    drop_d  = sat16(drop_q);
                    err_d   = sat16(err_q);
                    state_d = FILL;
                end else if (s_valid) begin
                    ch_d = ch_q + CHW'(1);
                    if (mask_q[ch_d]) begin
                        word_w = put_lane(pack_q, lanes_q, s_data);
                        if (ch_d == last_q || lanes_q == LW'(L - 1)) begin
                            tl       = (ch_d == last_q);
                            wr_en    = 1'b1;
                            wr_entry = {tl, tl ? keep_of(lastn_q) : {KW{1'b1}}, word_w};
                            pack_d   = '0;
                            lanes_d  = '0;
                            words_d  = words_q + EW'(1);
                        end else begin
                            pack_d  = word_w;
                            lanes_d = lanes_q + LW'(1);
                        end
                    end
                    if (ch_d == CHW'(NUM_CH - 1)) state_d = IDLE;
                end
            end
            FILL: begin
                if (words_q == nw_q) begin
                    state_d = DROP;
                end else begin
                    tl       = (words_q == nw_q - EW'(1));
                    wr_en    = 1'b1;
                    wr_entry = {tl, tl ? keep_of(lastn_q) : {KW{1'b1}}, pack_q};
                    pack_d   = '0;
                    lanes_d  = '0;
                    words_d  = words_q + EW'(1);
                    if (tl) state_d = DROP;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_q) begin
            wr_en    = 1'b1;
            wr_entry = {1'b1, keep_of(lastn_q), pack_q};
            pack_d   = '0;
            lanes_d  = '0;
            words_d  = words_q + EW'(1);
        end
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_q <= IDLE;  ch_q <= '0;    mask_q <= '0;  last_q <= '0;
            nw_q <= '0;       lastn_q <= '0; pack_q <= '0;  lanes_q <= '0;
            words_q <= '0;    flush_q <= 1'b0;
            frame_q <= '0;    drop_q <= '0;  err_q <= '0;
        end else begin
            state_q <= state_d; ch_q <= ch_d;       mask_q <= mask_d; last_q <= last_d;
            nw_q <= nw_d;       lastn_q <= lastn_d; pack_q <= pack_d; lanes_q <= lanes_d;
            words_q <= words_d; flush_q <= flush_d;
            frame_q <= frame_d; drop_q <= drop_d;   err_q <= err_d;
        end
    end

    // Occupancy counts the output register too, so reserved space covers every held word
    assign rd_en = (mem_cnt_q != '0) && (!out_valid_q || m_axis.M_AXIS_TREADY);

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) begin
                rd_ptr_q    <= rd_ptr_q + AW'(1);
                out_q       <= mem[rd_ptr_q];
                out_valid_q <= 1'b1;
            end else if (m_axis.M_AXIS_TREADY) begin
                out_valid_q <= 1'b0;
            end
            case ({wr_en, rd_en})
                2'b10:   mem_cnt_q <= mem_cnt_q + (AW+1)'(1);
                2'b01:   mem_cnt_q <= mem_cnt_q - (AW+1)'(1);
                default: mem_cnt_q <= mem_cnt_q;
            endcase
        end
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (wr_en) mem[wr_ptr_q] <= wr_entry;
    end

    assign m_axis.M_AXIS_TDATA  = out_q[TDATA_W-1:0];
    assign m_axis.M_AXIS_TKEEP  = out_q[TDATA_W +: KW];
    assign m_axis.M_AXIS_TLAST  = out_q[FW-1];
    assign m_axis.M_AXIS_TVALID = out_valid_q;
    assign frame_cnt = frame_q;
    assign drop_cnt  = drop_q;
    assign err_cnt   = err_q;
endmodule

// File: tb/tb_seeg_axis_frame_packer.sv
// tb/tb_seeg_axis_frame_packer.sv - randomized bench for the SEEG frame packer against a frame-level model
module tb_seeg_axis_frame_packer;
    localparam int NUM_CH = 32;
    localparam int SW     = 16;
    localparam int TW     = 64;
    localparam int L      = TW / SW;
    localparam int KW     = TW / 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] ch_mask;
    logic              s_valid, s_sof;
    logic [SW-1:0]     s_data;
    logic [15:0]       frame_cnt, drop_cnt, err_cnt;
    logic [SW-1:0]     smp [NUM_CH];

    always #5 clk = ~clk;

    seeg_axis_frame_packer_if #(.TDATA_W(TW)) axis ();

    seeg_axis_frame_packer #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SW), .TDATA_W(TW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .ch_mask(ch_mask),
        .s_valid(s_valid), .s_sof(s_sof), .s_data(s_data), .m_axis(axis),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    int            n_cmp, n_err;
    int            m_frame, m_drop, m_err;
    int            ready_mode;
    logic [73:0]   exp_q [$];
    logic [73:0]   held, cur;
    bit            stalled;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_frame"}, 80'(frame_cnt), 80'(16'(m_frame)));
        check({tag, "_drop"},  80'(drop_cnt),  80'(16'(m_drop)));
        check({tag, "_err"},   80'(err_cnt),   80'(16'(m_err)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       axis.M_AXIS_TREADY = 1'b1;
            1:       axis.M_AXIS_TREADY = 1'b0;
            2:       axis.M_AXIS_TREADY = ~axis.M_AXIS_TREADY;
            default: axis.M_AXIS_TREADY = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Frame-level reference: enabled samples in channel order, zeroed past a truncation point, cut into L-lane words
    task automatic model_frame(input logic [NUM_CH-1:0] mask, input int trunc);
        logic [SW-1:0] vals [$];
        logic [TW-1:0] w;
        logic [KW-1:0] k;
        int e, nw, n;
        for (int c = 0; c < NUM_CH; c++)
            if (mask[c]) vals.push_back((c < trunc) ? smp[c] : '0);
        e = vals.size();
        exp_q.push_back({1'b1, (e == 0), {KW{1'b1}}, 16'h0, 16'(e), 16'(m_frame), 16'hEE6A});
        nw = (e + L - 1) / L;
        for (int j = 0; j < nw; j++) begin
            n = (j == nw - 1) ? e - j * L : L;
            w = '0;
            k = '0;
            for (int i = 0; i < n; i++) begin
                w[i*SW +: SW]         = vals[j*L + i];
                k[i*(SW/8) +: (SW/8)] = '1;
            end
            exp_q.push_back({1'b1, (j == nw - 1), k, w});
        end
    endtask

    task automatic send_frame(input logic [NUM_CH-1:0] mask, input int trunc, input bit fits, input bit lat);
        if (fits) model_frame(mask, trunc);
        else m_drop++;
        m_frame++;
        ch_mask = mask;
        for (int c = 0; c < NUM_CH; c++) begin
            s_valid = 1'b1;
            s_sof   = (c == 0) || (c == trunc);
            s_data  = smp[c];
            tick();
            if (c == 0) ch_mask = NUM_CH'($urandom);
            if (lat && c == 0) check("lat_before_out", 80'(axis.M_AXIS_TVALID), 80'd0);
            if (lat && c == 1) check("lat_header_out", 80'(axis.M_AXIS_TVALID), 80'd1);
            if (c == trunc) begin
                m_err++;
                m_drop++;
                m_frame++;
                break;
            end
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic idle(input int n, input bit stray);
        for (int i = 0; i < n; i++) begin
            s_valid = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            s_sof   = 1'b0;
            s_data  = SW'($urandom);
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || axis.M_AXIS_TVALID) && t < 3000) begin
            tick();
            t++;
        end
        check("drain", 80'(exp_q.size()), 80'd0);
    endtask

    task automatic rand_smp();
        for (int c = 0; c < NUM_CH; c++) smp[c] = SW'($urandom);
    endtask

    task automatic ramp_smp();
        for (int c = 0; c < NUM_CH; c++) smp[c] = SW'(c);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            cur = {axis.M_AXIS_TVALID, axis.M_AXIS_TLAST, axis.M_AXIS_TKEEP, axis.M_AXIS_TDATA};
            if (stalled) check("stall_hold", 80'(cur), 80'(held));
            if (axis.M_AXIS_TVALID && axis.M_AXIS_TREADY) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL extra_word: observed %h expected none", cur);
                end else begin
                    check("stream_word", 80'(cur), 80'(exp_q.pop_front()));
                end
            end
            stalled = axis.M_AXIS_TVALID && !axis.M_AXIS_TREADY;
            held    = cur;
        end
    end

    initial begin
        n_cmp = 0; n_err = 0; m_frame = 0; m_drop = 0; m_err = 0;
        ready_mode = 0; axis.M_AXIS_TREADY = 1'b1;
        s_valid = 1'b0; s_sof = 1'b0; s_data = '0; ch_mask = '1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 80'(axis.M_AXIS_TVALID), 80'd0);
        check("rst_tdata",  80'(axis.M_AXIS_TDATA),  80'd0);
        check("rst_tkeep",  80'(axis.M_AXIS_TKEEP),  80'd0);
        check("rst_tlast",  80'(axis.M_AXIS_TLAST),  80'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_cnts("rst");

        ramp_smp();
        send_frame('1, NUM_CH, 1'b1, 1'b1);
        wait_drain();
        rand_smp();
        send_frame(NUM_CH'(1), NUM_CH, 1'b1, 1'b0);
        rand_smp();
        send_frame('0, NUM_CH, 1'b1, 1'b0);
        wait_drain();
        check_cnts("basic");

        repeat (6) begin
            rand_smp();
            send_frame(NUM_CH'($urandom), NUM_CH, 1'b1, 1'b0);
        end
        wait_drain();
        check_cnts("b2b");

        ready_mode = 1;
        tick();
        ramp_smp();
        send_frame('1, NUM_CH, 1'b1, 1'b0);
        send_frame('1, NUM_CH, 1'b0, 1'b0);
        send_frame('1, NUM_CH, 1'b0, 1'b0);
        idle(4, 1'b1);
        check("bp_tvalid", 80'(axis.M_AXIS_TVALID), 80'd1);
        check("bp_queued", 80'(exp_q.size()), 80'd9);
        check_cnts("bp");
        ready_mode = 0;
        wait_drain();

        ramp_smp();
        send_frame('1, 10, 1'b1, 1'b0);
        idle(12, 1'b1);
        check_cnts("early");
        rand_smp();
        send_frame(NUM_CH'($urandom), NUM_CH, 1'b1, 1'b0);
        wait_drain();
        repeat (5) begin
            rand_smp();
            send_frame(NUM_CH'($urandom), $urandom_range(1, NUM_CH - 1), 1'b1, 1'b0);
            idle(12, 1'b1);
            wait_drain();
        end
        check_cnts("early_rand");

        ready_mode = 2;
        repeat (4) begin
            rand_smp();
            send_frame(NUM_CH'($urandom), NUM_CH, 1'b1, 1'b0);
            wait_drain();
        end
        ready_mode = 3;
        repeat (4) begin
            rand_smp();
            send_frame(NUM_CH'($urandom) | NUM_CH'(1), NUM_CH, 1'b1, 1'b0);
            wait_drain();
        end
        ready_mode = 0;
        tick();
        check_cnts("stall");

        ready_mode = 1;
        tick();
        ch_mask = '1;
        for (int c = 0; c < 20; c++) begin
            s_valid = 1'b1;
            s_sof   = (c == 0);
            s_data  = SW'(c);
            tick();
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        check("pre_rst_tvalid", 80'(axis.M_AXIS_TVALID), 80'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 80'(axis.M_AXIS_TVALID), 80'd0);
        check("mid_rst_tdata",  80'(axis.M_AXIS_TDATA),  80'd0);
        exp_q.delete();
        m_frame = 0; m_drop = 0; m_err = 0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        ready_mode = 0;
        tick();
        check_cnts("post_rst");
        ramp_smp();
        send_frame('1, NUM_CH, 1'b1, 1'b0);
        wait_drain();
        check_cnts("post_rst_frame");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seeg_axis_frame_packer.md
# seeg_axis_frame_packer

Parametrised sample-to-stream packer that sits between the SEEG acquisition core and the AXI-Stream DMA path, in the M_AXIS clock domain. It takes one channel-serial sample per cycle and applies a per-frame channel-enable mask. It packs enabled samples into TDATA_W-bit words, prefixes each frame with a header word, buffers the result in a FIFO and emits one AXI-Stream packet per frame. Frames that cannot fit in the FIFO are dropped whole, and truncated frames are zero-filled, so downstream never sees a malformed packet.

## Interface
- NUM_CH, 32: channels per frame (1..256).
- SAMPLE_W, 16: sample width. Must be a multiple of 8 and ≤32.
- TDATA_W, 64: stream width. Must be a multiple of 32 and ≥64. L = TDATA_W/SAMPLE_W lanes.
- FIFO_DEPTH, 16: FIFO words, a power of 2. Must be ≥ 1+ceil(NUM_CH/L).
- M_AXIS_ACLK  in  1  sole clock.
- M_AXIS_ARESETN  in  1  reset, asynchronous, active-low.
- ch_mask  in  NUM_CH  channel enables. Sampled only when a SOF is accepted.
- s_valid  in  1  sample strobe. There is no backpressure on this input.
- s_sof  in  1  qualifies s_valid. The sample is channel 0 of a new frame.
- s_data  in  SAMPLE_W  sample value.
- M_AXIS_TDATA  out  TDATA_W  stream data.
- M_AXIS_TKEEP  out  TDATA_W/8  byte enables.
- M_AXIS_TLAST  out  1  last word of a frame.
- M_AXIS_TVALID  out  1  stream valid.
- M_AXIS_TREADY  in  1  stream ready.
- frame_cnt  out  16  SOFs accepted, wrapping.
- drop_cnt  out  16  frames dropped, saturating.
- err_cnt  out  16  early-SOF truncations, saturating.

## Operation
- Channel index ch: internal counter, incremented on every accepted sample and reset to 0 by SOF. There is no channel input.
- States:
  - IDLE: waits for s_valid&s_sof.
  - RUN: accepts channels 1..NUM_CH-1.
  - FILL: zero-completes a truncated frame.
  - DROP: discards samples until the next SOF.
- SOF in IDLE or DROP:
  - frame_cnt++.
  - Latch mask, E = popcount(mask), and last-enabled index.
  - Compute need = 1+ceil(E/L).
  - If FIFO_DEPTH−occupancy ≥ need: write the header and go to RUN (stay in IDLE if NUM_CH=1). Otherwise drop_cnt++ and go to DROP.
- Header word:
  - [15:0]=16'hEE6A, [31:16]=frame_cnt value for this frame, [47:32]=E, rest zero.
  - TKEEP all ones.
  - TLAST=1 only if E=0.
- Packing:
  - Enabled samples fill lanes LSB-first. Disabled channels are discarded but still advance ch.
  - A word is written when L lanes are full, or when the last enabled channel is packed (TLAST=1).
  - Partial word: unused lanes zero, TKEEP low (lanes×SAMPLE_W/8) bits set.
- Sample at ch=NUM_CH-1 → IDLE.
- SOF in RUN (early): err_cnt++, drop_cnt++, frame_cnt++. The new frame is discarded; go to FILL.
- FILL:
  - Writes one word per cycle: first the pending lanes plus zero samples, then all-zero full words.
  - Continues until ceil(E/L) data words exist. Last word gets TLAST with the normal partial TKEEP.
  - Then → DROP.
  - s_valid is ignored in FILL.
- s_valid without SOF in IDLE or DROP: ignored.
- FIFO: one write and one read per cycle max; occupancy updates simultaneously. Entries hold {TLAST,TKEEP,TDATA}.
- Counters saturate at 16'hFFFF where marked; frame_cnt wraps.

## Timing
- Reset (async assert, sync release) values:
  - TVALID=0, TDATA=0, TKEEP=0, TLAST=0.
  - All counters 0, state IDLE, FIFO empty.
  - Reset mid-frame discards all buffered and partial data.
- Header is written on the edge that accepts the SOF. A data word is written on the edge after its last lane is packed. So at most one FIFO write occurs per edge.
- Latency into an empty FIFO: TVALID rises 1 cycle after the FIFO write. The header is visible 2 edges after the SOF sample.
- Transfer on TVALID&TREADY. TDATA/TKEEP/TLAST hold stable while TVALID&!TREADY.
- Sustained output: 1 word/cycle with TREADY=1.
- A full FIFO cannot occur mid-frame, because space is reserved at SOF.

## Test plan
- Defaults, mask=32'hFFFFFFFF, samples 0..31 (value = ch), TREADY=1 → 9 words:
  - Header 0x0000_0020_0000_EE6A.
  - Word1 0x0003_0002_0001_0000 … word8 with TLAST.
  - All TKEEP=0xFF.
- mask=32'h1 → header, then one word with TDATA=sample0, TKEEP=0x03, TLAST=1. mask=0 → header only, [47:32]=0, TLAST=1.
- TREADY=0, three full frames:
  - Frame 1 buffered (occupancy 9). Frames 2 and 3 dropped, drop_cnt=2, frame_cnt=3.
  - Release TREADY → exactly 9 words, header seq 0.
- Full mask, SOF reasserted at ch=10:
  - err_cnt=1, drop_cnt=1.
  - Frame has 8 data words. Word3 = samples 8,9 plus zeros; words 4–8 are zero. Word8 has TLAST.
  - Next SOF frame: seq=2.
- TREADY toggling 1-0 per cycle → no TDATA change while stalled; word order matches the ideal reference model.
- Assert reset at ch=20 → TVALID low immediately. After release, the next frame starts cleanly with seq 0 and all counters at 0.
